// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction's
// steps, decodes datapath strobes/selects from the current state, and bounds memory waits.
module multicycle_main_control #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Mem_Ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALU_Op,
    output logic [1:0] PCSource,
    output logic       Illegal_o,
    output logic       Timeout_o,
    output logic [3:0] State_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_st;
    logic             timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALU_Op      = 2'b00;
        PCSource    = 2'b00;
        Illegal_o   = 1'b0;
        state_d     = state_q;

        wait_st     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        timeout_hit = (TIMEOUT_CYCLES != 0) && wait_st && !Mem_Ready && (cnt_q == CNT_TO);

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = Mem_Ready;
                PCWrite = Mem_Ready;
                if (Mem_Ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_EXEC_I;
                    default: begin
                        Illegal_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (Mem_Ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (Mem_Ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALU_Op  = 2'b10;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_Op      = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Abort the stalled access; from FETCH this simply restarts the fetch.
        if (timeout_hit) state_d = S_FETCH;

        if ((state_d != state_q) || Mem_Ready || timeout_hit) cnt_d = '0;
        else if (wait_st && (cnt_q != CNT_MAX))               cnt_d = cnt_q + 1'b1;
        else                                                  cnt_d = cnt_q;

        Timeout_o = timeout_hit;

        // Strobes are suppressed combinationally so nothing leaks out while reset is held.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            Illegal_o   = 1'b0;
            Timeout_o   = 1'b0;
        end
    end

    assign State_o = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: directed scenarios plus randomized
// instruction streams checked cycle by cycle against an instruction-level trace model.
module tb_multicycle_main_control;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Opcode = '0;
    logic       Mem_Ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal_o, Timeout_o;
    logic [1:0] ALUSrcB, ALU_Op, PCSource;
    logic [3:0] State_o;

    int total = 0;
    int bad   = 0;

    multicycle_main_control #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Mem_Ready(Mem_Ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op),
        .PCSource(PCSource), .Illegal_o(Illegal_o), .Timeout_o(Timeout_o), .State_o(State_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       ill, tmo;
    } ctl_t;

    ctl_t obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALU_Op, PCSource, Illegal_o, Timeout_o};

    typedef struct {
        bit         rdy;
        logic [5:0] op;
        int         st;
        ctl_t       c;
    } ent_t;

    ent_t tq[$];

    // Control table of the datapath, one row per step of the instruction walk.
    function automatic ctl_t ctl(int st, bit rdy, bit ill, bit tmo);
        ctl_t c = '0;
        case (st)
            0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
            1:  c.srcb = 2'b11;
            2:  begin c.srca = 1; c.srcb = 2'b10; end
            3:  begin c.mrd = 1; c.iord = 1; end
            4:  begin c.m2r = 1; c.rw = 1; end
            5:  begin c.mwr = 1; c.iord = 1; end
            6:  begin c.srca = 1; c.aluop = 2'b10; end
            7:  begin c.rdst = 1; c.rw = 1; end
            8:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
            9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
            10: begin c.srca = 1; c.srcb = 2'b10; end
            11: c.rw = 1;
            default: c = '0;
        endcase
        c.ill = ill;
        c.tmo = tmo;
        return c;
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    task automatic push(int st, bit rdy, logic [5:0] op, bit ill, bit tmo);
        ent_t e;
        e.rdy = rdy; e.op = op; e.st = st; e.c = ctl(st, rdy, ill, tmo);
        tq.push_back(e);
    endtask

    // A memory step waiting w cycles; more than TO idle cycles aborts it.
    task automatic add_wait(int st, int w, output bit ab);
        ab = 0;
        for (int i = 0; i < w; i++) begin
            if (i == TO) begin
                push(st, 0, 6'($urandom), 0, 1);
                ab = 1;
                return;
            end
            push(st, 0, 6'($urandom), 0, 0);
        end
        push(st, 1, 6'($urandom), 0, 0);
    endtask

    task automatic add_instr(logic [5:0] op, int wf, int wm);
        bit ab;
        add_wait(0, wf, ab);
        if (ab) return;
        push(1, 1'($urandom), op, !legal(op), 0);
        case (op)
            6'h00: begin push(6, 1'($urandom), 6'($urandom), 0, 0); push(7, 1'($urandom), 6'($urandom), 0, 0); end
            6'h23: begin
                push(2, 1'($urandom), op, 0, 0);
                add_wait(3, wm, ab);
                if (!ab) push(4, 1'($urandom), 6'($urandom), 0, 0);
            end
            6'h2B: begin push(2, 1'($urandom), op, 0, 0); add_wait(5, wm, ab); end
            6'h04: push(8, 1'($urandom), 6'($urandom), 0, 0);
            6'h02: push(9, 1'($urandom), 6'($urandom), 0, 0);
            6'h08: begin push(10, 1'($urandom), 6'($urandom), 0, 0); push(11, 1'($urandom), 6'($urandom), 0, 0); end
            default: ;
        endcase
    endtask

    task automatic apply_reset();
        rst = 1; Mem_Ready = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; Mem_Ready = 1; Opcode = '0;
        repeat (3) begin
            @(negedge clk); #1;
            total++;
            if (State_o !== 4'd0 ||
                {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, Illegal_o, Timeout_o} !== 8'h00 ||
                ALUSrcB !== 2'b01 || ALU_Op !== 2'b00) begin
                bad++;
                $display("FAIL reset_hold state=%0d ctl=%h required state=0 strobes=0 srcb=01", State_o, obs);
            end
        end
        @(negedge clk); rst = 0; #1;
        total++;
        if (State_o !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1 || ALUSrcB !== 2'b01 || ALU_Op !== 2'b00) begin
            bad++;
            $display("FAIL reset_release state=%0d irw=%b pcw=%b srcb=%b aluop=%b required 0,1,1,01,00",
                     State_o, IRWrite, PCWrite, ALUSrcB, ALU_Op);
        end
        @(posedge clk); #1;
        total++;
        if (State_o !== 4'd1) begin
            bad++;
            $display("FAIL reset_first_edge state=%0d required 1", State_o);
        end
    endtask

    task automatic test_instr_mix();
        int cyc = 0;
        ent_t e;
        apply_reset();
        tq.delete();
        add_instr(6'h00, 0, 0);
        add_instr(6'h23, 1, 3);
        add_instr(6'h2B, 0, 0);
        add_instr(6'h04, 0, 0);
        add_instr(6'h02, 0, 0);
        add_instr(6'h08, 0, 0);
        add_instr(6'h3F, 0, 0);
        add_instr(6'h00, 2, 0);
        while (tq.size() > 0) begin
            e = tq.pop_front();
            @(negedge clk); rst = 0; Opcode = e.op; Mem_Ready = e.rdy; #1;
            total++;
            if (State_o !== 4'(e.st) || obs !== e.c) begin
                bad++;
                $display("FAIL instr_mix cyc=%0d state=%0d required %0d ctl=%h required %h", cyc, State_o, e.st, obs, e.c);
            end
            cyc++;
        end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        ent_t e;
        apply_reset();
        tq.delete();
        add_instr(6'h2B, 0, TO + 1);
        add_instr(6'h2B, 0, TO);
        add_instr(6'h23, 0, TO + 1);
        add_instr(6'h23, 0, TO);
        add_instr(6'h00, TO + 1, 0);
        add_instr(6'h08, TO, 0);
        while (tq.size() > 0) begin
            e = tq.pop_front();
            @(negedge clk); rst = 0; Opcode = e.op; Mem_Ready = e.rdy; #1;
            total++;
            if (State_o !== 4'(e.st) || obs !== e.c) begin
                bad++;
                $display("FAIL timeout cyc=%0d state=%0d required %0d ctl=%h required %h", cyc, State_o, e.st, obs, e.c);
            end
            cyc++;
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        ent_t e;
        logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        logic [5:0] op;
        int wf, wm;
        apply_reset();
        tq.delete();
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            wf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 1);
            wm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 2);
            add_instr(op, wf, wm);
        end
        while (tq.size() > 0) begin
            e = tq.pop_front();
            @(negedge clk); rst = 0; Opcode = e.op; Mem_Ready = e.rdy; #1;
            total++;
            if (State_o !== 4'(e.st) || obs !== e.c) begin
                bad++;
                $display("FAIL random cyc=%0d op=%h state=%0d required %0d ctl=%h required %h",
                         cyc, e.op, State_o, e.st, obs, e.c);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_midway();
        apply_reset();
        @(negedge clk); rst = 0; Mem_Ready = 1; Opcode = 6'h00;
        @(negedge clk); Opcode = 6'h2B;
        @(negedge clk);
        @(negedge clk); Mem_Ready = 0; #1;
        total++;
        if (State_o !== 4'd5 || MemWrite !== 1'b1) begin
            bad++;
            $display("FAIL midway_setup state=%0d memwrite=%b required 5,1", State_o, MemWrite);
        end
        rst = 1; #1;
        total++;
        if (State_o !== 4'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0 || MemRead !== 1'b0) begin
            bad++;
            $display("FAIL midway_reset state=%0d memwrite=%b regwrite=%b memread=%b required 0,0,0,0",
                     State_o, MemWrite, RegWrite, MemRead);
        end
    endtask

    initial begin
        test_reset();
        test_instr_mix();
        test_timeout();
        test_random();
        test_reset_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath; sits directly upstream of ALUControl and drives its ALU_Op input.
- Decodes the 6-bit Opcode held in the instruction register.
- Sequences fetch, decode, execute, memory and write-back steps, and generates all datapath strobes and mux selects.
- Waits on a memory ready handshake, with a bounded timeout.

Parameters:
- TIMEOUT_CYCLES, 16: Mem_Ready=0 cycles tolerated in a memory state before abort; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- Opcode  in  6  instr[31:26] from IR
- Mem_Ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (beq)
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  1=MDR to register file
- RegDst  out  1  1=rd, 0=rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
- ALU_Op  out  2  to ALUControl: 00 add, 01 sub, 10 R-type funct
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- Illegal_o  out  1  one-cycle pulse: unsupported opcode
- Timeout_o  out  1  one-cycle pulse: memory wait aborted
- State_o  out  4  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11. Encodings 12-15 fall through to FETCH on the next edge.
- Outputs are decoded from the current state; any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_Op=00, PCSource=00.
  - IRWrite=PCWrite=Mem_Ready (Mealy).
  - Mem_Ready=1 -> DECODE; otherwise stay.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALU_Op=00.
  - Next state by Opcode: 000000 -> EXEC_R; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> EXEC_I.
  - Any other Opcode -> Illegal_o=1 this cycle, next FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_Op=00. 100011 -> MEM_RD; otherwise -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Mem_Ready -> MEM_WB.
- MEM_WB: MemtoReg=1, RegDst=0, RegWrite=1 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1, held until Mem_Ready -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_Op=10 -> R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_Op=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALU_Op=00 -> I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- Instruction latency in cycles with zero wait: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Wait counter:
  - Cleared on every state transition and whenever Mem_Ready=1.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with Mem_Ready=0.
  - When the counter equals TIMEOUT_CYCLES and Mem_Ready=0: Timeout_o=1 that cycle, next state FETCH, counter cleared. In FETCH this restarts the fetch.
  - Mem_Ready=1 in the timeout cycle wins: normal transition, no pulse.
  - Counter saturates; it never wraps.
- Reset:
  - rst=1 forces state=FETCH and counter=0 immediately, with no clock needed.
  - While rst=1, all strobes are forced to 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, Illegal_o, Timeout_o.
  - Selects keep their FETCH values.
  - Reset mid-instruction abandons it; no partial RegWrite or MemWrite is issued after rst asserts.
- Opcode is sampled only in DECODE and MEM_ADDR; it is ignored in other states.

Test Plan:
- Reset: rst=1 for 3 cycles with Mem_Ready=1 -> State_o=0 and all strobes 0 throughout. Release rst -> first edge sees IRWrite=PCWrite=1, ALUSrcB=01, ALU_Op=00.
- R-type: Opcode=000000, Mem_Ready=1 -> State_o sequence 0,1,6,7,0. EXEC_R has ALU_Op=10 and ALUSrcB=00. R_WB has RegWrite=1 and RegDst=1.
- lw with wait: Opcode=100011, Mem_Ready low for 3 cycles in MEM_RD -> sequence 0,1,2,3,3,3,3,4,0. MemRead=IorD=1 held through the wait. MEM_WB has MemtoReg=1 and RegWrite=1.
- sw, beq, j, addi:
  - sw (101011) -> sequence 0,1,2,5,0 with MemWrite=1 in state 5.
  - beq (000100) -> state 8 with ALU_Op=01, PCWriteCond=1, PCSource=01.
  - j (000010) -> state 9 with PCWrite=1, PCSource=10.
  - addi (001000) -> sequence 0,1,10,11,0.
- Illegal opcode: Opcode=111111 -> Illegal_o=1 for exactly the DECODE cycle, then State_o=0, no RegWrite.
- Timeout: TIMEOUT_CYCLES=4, Mem_Ready=0 in MEM_WR -> Timeout_o pulses one cycle, then State_o=0. Repeat with Mem_Ready rising on the timeout cycle -> no pulse, normal FETCH. Assert rst during MEM_WR -> MemWrite drops to 0 immediately.
